// File: rtl/rc5_encrypt_core_pkg.sv
// Shared RC5-32/12 parameters, word/address types and rotate helper.
// Also used by the key-expansion block so both sides agree on the S geometry.
package rc5_encrypt_core_pkg;

  localparam int W        = 32;
  localparam int R        = 12;
  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);
  localparam int LOG_W    = $clog2(W);

  typedef logic [W-1:0]        word_t;
  typedef logic [T_LENGTH-1:0] addr_t;

  localparam addr_t K_LAST = addr_t'(T - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Circular left rotate; an amount of 0 returns x unchanged since x >> W is 0.
  function automatic word_t rotl(input word_t x, input logic [LOG_W-1:0] n);
    return (x << n) | (x >> (W - int'(n)));
  endfunction

endpackage

// File: rtl/rc5_encrypt_core_if.sv
// Start/plaintext/ciphertext handshake plus the S-array read port of the core.
interface rc5_encrypt_core_if;
  import rc5_encrypt_core_pkg::*;

  logic  start;
  word_t A_in;
  word_t B_in;
  addr_t S_address;
  word_t S_sub_i;
  word_t A_out;
  word_t B_out;
  logic  busy;
  logic  done;

  modport slave (
    input  start, A_in, B_in, S_sub_i,
    output S_address, A_out, B_out, busy, done
  );

  modport master (
    output start, A_in, B_in, S_sub_i,
    input  S_address, A_out, B_out, busy, done
  );

endinterface

// File: rtl/rc5_encrypt_core_half_round.sv
// One RC5 half-round: ((x ^ y) <<< y[log2(w)-1:0]) + s, purely combinational.
module rc5_half_round
  import rc5_encrypt_core_pkg::*;
(
  input  word_t i_x,
  input  word_t i_y,
  input  word_t i_s,
  output word_t o_z
);

  word_t w_mix;

  assign w_mix = i_x ^ i_y;
  assign o_z   = rotl(w_mix, i_y[LOG_W-1:0]) + i_s;

endmodule

// File: rtl/rc5_encrypt_core.sv
// RC5 encryption core: streams S[0..T-1] through a synchronous read port,
// applies one half-round per word and returns A/B with a one-cycle done pulse.
module rc5_encrypt_core
  import rc5_encrypt_core_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  rc5_encrypt_core_if.slave core_bus
);

  state_t r_state, w_state_next;
  word_t  r_a, w_a_next;
  word_t  r_b, w_b_next;
  word_t  r_a_out, w_a_out_next;
  word_t  r_b_out, w_b_out_next;
  addr_t  r_addr, w_addr_next;
  addr_t  r_k, w_k_next;
  logic   r_primed, w_primed_next;
  logic   r_done, w_done_next;

  word_t  w_hr_x;
  word_t  w_hr_y;
  word_t  w_hr_out;
  logic   w_k_odd;
  logic   w_k_last;

  assign w_k_odd  = r_k[0];
  assign w_k_last = (r_k == K_LAST);

  // k=0/1 are plain additions: forcing y to zero collapses the half-round to x + s.
  assign w_hr_x = w_k_odd ? r_b : r_a;
  assign w_hr_y = (r_k < addr_t'(2)) ? '0 : (w_k_odd ? r_a : r_b);

  rc5_half_round u_half_round (
    .i_x (w_hr_x),
    .i_y (w_hr_y),
    .i_s (core_bus.S_sub_i),
    .o_z (w_hr_out)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_out  <= '0;
      r_b_out  <= '0;
      r_addr   <= '0;
      r_k      <= '0;
      r_primed <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_a_out  <= w_a_out_next;
      r_b_out  <= w_b_out_next;
      r_addr   <= w_addr_next;
      r_k      <= w_k_next;
      r_primed <= w_primed_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_a_out_next  = r_a_out;
    w_b_out_next  = r_b_out;
    w_addr_next   = r_addr;
    w_k_next      = r_k;
    w_primed_next = r_primed;
    w_done_next   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (core_bus.start) begin
          w_state_next  = ST_RUN;
          w_a_next      = core_bus.A_in;
          w_b_next      = core_bus.B_in;
          w_k_next      = '0;
          w_addr_next   = '0;
          w_primed_next = 1'b0;
        end
      end

      ST_RUN: begin
        if (r_addr != K_LAST) begin
          w_addr_next = r_addr + addr_t'(1);
        end
        // The first RUN edge only fills the RAM read pipeline; S[0] arrives one edge later.
        if (!r_primed) begin
          w_primed_next = 1'b1;
        end else begin
          if (w_k_odd) begin
            w_b_next = w_hr_out;
          end else begin
            w_a_next = w_hr_out;
          end
          w_k_next = r_k + addr_t'(1);
          if (w_k_last) begin
            w_state_next  = ST_IDLE;
            w_addr_next   = '0;
            w_done_next   = 1'b1;
            w_a_out_next  = w_k_odd ? r_a : w_hr_out;
            w_b_out_next  = w_k_odd ? w_hr_out : r_b;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign core_bus.S_address = r_addr;
  assign core_bus.A_out     = r_a_out;
  assign core_bus.B_out     = r_b_out;
  assign core_bus.busy      = (r_state == ST_RUN);
  assign core_bus.done      = r_done;

endmodule

// File: tb/tb_rc5_encrypt_core.sv
// Scoreboard bench for rc5_encrypt_core: stimulus pushes expected ciphertext,
// a monitor pops and compares on every done pulse.
module tb_rc5_encrypt_core;
  import rc5_encrypt_core_pkg::*;

  typedef struct {
    word_t a;
    word_t b;
  } res_t;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  rc5_encrypt_core_if bus_if();

  rc5_encrypt_core dut (
    .clk1     (clk1),
    .rst      (rst),
    .core_bus (bus_if)
  );

  always #5 clk1 = ~clk1;

  word_t s_mem [T];
  always @(posedge clk1) bus_if.S_sub_i <= s_mem[bus_if.S_address];

  res_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t rol(input word_t x, input int n);
    word_t v;
    v = x;
    for (int i = 0; i < n; i++) v = {v[W-2:0], v[W-1]};
    return v;
  endfunction

  function automatic res_t model(input word_t a_in, input word_t b_in);
    res_t  res;
    word_t a;
    word_t b;
    a = a_in + s_mem[0];
    b = b_in + s_mem[1];
    for (int i = 1; i <= R; i++) begin
      a = rol(a ^ b, int'(b[LOG_W-1:0])) + s_mem[2*i];
      b = rol(b ^ a, int'(a[LOG_W-1:0])) + s_mem[2*i+1];
    end
    res.a = a;
    res.b = b;
    return res;
  endfunction

  task automatic load_zero_key_schedule();
    word_t l [4];
    word_t a;
    word_t b;
    word_t ab;
    int    i;
    int    j;
    s_mem[0] = 32'hB7E15163;
    for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) l[k] = '0;
    a = '0; b = '0; i = 0; j = 0;
    for (int n = 0; n < 3 * T; n++) begin
      a = rol(s_mem[i] + a + b, 3);
      s_mem[i] = a;
      ab = a + b;
      b = rol(l[j] + ab, int'(ab[LOG_W-1:0]));
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endtask

  // Called at a negedge with the core idle; start is sampled at the next edge (E0).
  task automatic start_block(input word_t a, input word_t b, input res_t exp);
    sb_q.push_back(exp);
    bus_if.A_in  = a;
    bus_if.B_in  = b;
    bus_if.start = 1'b1;
    @(posedge clk1);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int stop_at, input bit glitch, input bit mid,
                           input word_t mid_a, input word_t mid_b);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      @(negedge clk1);
      if (bus_if.done) begin
        seen = 1'b1;
        check("latency", 64'(cyc), 64'(T + 1));
        check("busy_at_done", 64'(bus_if.busy), 64'd0);
        check("addr_at_done", 64'(bus_if.S_address), 64'd0);
      end else begin
        check("busy", 64'(bus_if.busy), 64'd1);
        check("s_address", 64'(bus_if.S_address), 64'((cyc < T - 1) ? cyc : T - 1));
        if (mid && cyc == 2) check("mid_A", 64'(dut.r_a), 64'(mid_a));
        if (mid && cyc == 3) check("mid_B", 64'(dut.r_b), 64'(mid_b));
        bus_if.start = glitch && (cyc == 4 || cyc == 14);
        if (cyc == stop_at) return;
        @(posedge clk1);
        cyc++;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk1);
      if (!rst && bus_if.done) begin
        done_cnt++;
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          $display("txn %0d: A_out=%h B_out=%h exp_A=%h exp_B=%h",
                   done_cnt, bus_if.A_out, bus_if.B_out, e.a, e.b);
          check("result_A", 64'(bus_if.A_out), 64'(e.a));
          check("result_B", 64'(bus_if.B_out), 64'(e.b));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int    base;
    res_t  exp;
    res_t  exp2;
    bus_if.start = 1'b0;
    bus_if.A_in  = '0;
    bus_if.B_in  = '0;
    for (int k = 0; k < T; k++) s_mem[k] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_s_address", 64'(bus_if.S_address), 64'd0);
    check("rst_A_out", 64'(bus_if.A_out), 64'd0);
    check("rst_B_out", 64'(bus_if.B_out), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    rst = 1'b0;
    @(negedge clk1);

    // All-zero S and plaintext.
    exp.a = '0; exp.b = '0;
    start_block('0, '0, exp);
    wait_done(-1, 1'b0, 1'b0, '0, '0);

    // Published RC5-32/12/16 all-zero-key vector.
    load_zero_key_schedule();
    exp.a = 32'hEEDBA521; exp.b = 32'h6D8F4B15;
    start_block('0, '0, exp);
    wait_done(-1, 1'b0, 1'b0, '0, '0);

    // S[k] = k with intermediate A/B checks.
    for (int k = 0; k < T; k++) s_mem[k] = word_t'(k);
    start_block(32'd1, 32'd0, model(32'd1, 32'd0));
    wait_done(-1, 1'b0, 1'b1, 32'd1, 32'd1);

    // Start pulses at E5 and E15 while busy must be ignored.
    base = done_cnt;
    start_block(32'h12345678, 32'h9ABCDEF0, model(32'h12345678, 32'h9ABCDEF0));
    wait_done(-1, 1'b1, 1'b0, '0, '0);
    repeat (3) @(negedge clk1);
    check("single_done", 64'(done_cnt - base), 64'd1);

    // Reset at E10 aborts the block in flight.
    base = done_cnt;
    start_block(32'hDEADBEEF, 32'h01234567, model(32'hDEADBEEF, 32'h01234567));
    wait_done(9, 1'b0, 1'b0, '0, '0);
    @(posedge clk1);
    #1 rst = 1'b1;
    #1;
    void'(sb_q.pop_back());
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
    check("abort_A_out", 64'(bus_if.A_out), 64'd0);
    check("abort_B_out", 64'(bus_if.B_out), 64'd0);
    check("abort_s_address", 64'(bus_if.S_address), 64'd0);
    @(negedge clk1);
    rst = 1'b0;
    repeat (40) @(negedge clk1);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    check("abort_busy_after", 64'(bus_if.busy), 64'd0);
    start_block(32'hDEADBEEF, 32'h01234567, model(32'hDEADBEEF, 32'h01234567));
    wait_done(-1, 1'b0, 1'b0, '0, '0);

    // Back-to-back: second start lands on the edge right after the done cycle.
    load_zero_key_schedule();
    exp  = model(32'hCAFEF00D, 32'h0BADC0DE);
    exp2 = model(32'h00000001, 32'h80000000);
    start_block(32'hCAFEF00D, 32'h0BADC0DE, exp);
    wait_done(-1, 1'b0, 1'b0, '0, '0);
    check("b2b_hold_A", 64'(bus_if.A_out), 64'(exp.a));
    check("b2b_hold_B", 64'(bus_if.B_out), 64'(exp.b));
    start_block(32'h00000001, 32'h80000000, exp2);
    wait_done(-1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
